// File: rtl/div_unit.sv
// Iterative restoring divider for the execute stage: DIV (signed quotient) and REMU
// (unsigned remainder), one quotient bit per cycle, stalling the pipeline while it works.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_REMU = 3'b100;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             valid_op, op_div, q_bit;
    logic [WIDTH-1:0] dvd_abs, dsr_abs, rem_next, quo_next;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        valid_op = start && (alu_control == OP_DIV || alu_control == OP_REMU);
        op_div   = (alu_control == OP_DIV);
        dvd_abs  = (op_div && dividend[WIDTH-1]) ? -dividend : dividend;
        dsr_abs  = (op_div && divisor[WIDTH-1])  ? -divisor  : divisor;

        // Partial remainder is always below the divisor, so a borrow out of bit WIDTH
        // means the trial subtraction failed and the shifted value is restored.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], q_bit};

        state_d  = state_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dsr_d    = dsr_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        res_d    = res_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (valid_op) begin
                    is_div_d = op_div;
                    neg_d    = op_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    dsr_d    = dsr_abs;
                    quo_d    = dvd_abs;
                    rem_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        res_d   = op_div ? '1 : dividend;
                        state_d = S_DONE;
                    end else if (op_div && dividend == {1'b1, {(WIDTH-1){1'b0}}} &&
                                 divisor == '1) begin
                        res_d   = dividend;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (cnt_q == '0) begin
                    res_d   = is_div_q ? (neg_q ? -quo_next : quo_next) : rem_next;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dsr_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dsr_q    <= dsr_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign stall     = ((state_q == S_IDLE) && valid_op) || (state_q == S_CALC);
    assign result    = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/REMU results, cycle-exact done timing,
// special cases, ignored starts, back-to-back issue and reset during a calculation.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  alu_control;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] DIV  = 3'b011;
    localparam logic [2:0] REMU = 3'b100;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .dividend(dividend), .divisor(divisor), .busy(busy), .stall(stall),
        .done(done), .result(result), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op at cycle 0 and follows it to its done pulse. Inputs are scrambled
    // after the accept edge unless hold is set, in which case start stays high until done.
    task automatic run_op(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_cyc, input bit hold);
        int cyc;
        int stall_cnt;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; alu_control = ctl; dividend = a; divisor = b;
        #1;
        cyc = 0; seen = 1'b0; stall_cnt = int'(stall);
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            if (!hold) begin
                start = 1'b0; alu_control = 3'b000;
                dividend = $urandom; divisor = $urandom;
            end
            #1;
            cyc++;
            if (done) seen = 1'b1;
            else stall_cnt += int'(stall);
        end
        check({tag, " done_cycle"}, seen ? cyc : 9999, exp_cyc);
        check({tag, " result"}, result, exp_res);
        check({tag, " stall_cycles"}, stall_cnt, exp_cyc);
        check({tag, " stall_at_done"}, {31'b0, stall}, 0);
        if (hold) start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        rst = 1'b1; start = 1'b0; alu_control = 3'b000; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset busy",   {31'b0, busy},  0);
        check("reset done",   {31'b0, done},  0);
        check("reset stall",  {31'b0, stall}, 0);
        check("reset result", result, 0);
        check("reset state",  {30'b0, dbg_state}, 0);
        @(posedge clk); #1; rst = 1'b0;

        run_op("div 100/7", DIV, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        @(posedge clk); #2;
        check("div 100/7 busy_after", {31'b0, busy}, 0);
        check("div 100/7 done_after", {31'b0, done}, 0);

        run_op("div -100/7",   DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        run_op("div 100/-7",   DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0);
        run_op("div -100/-7",  DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 1'b0);
        run_op("remu 100%7",   REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run_op("remu ffff%16", REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 1'b0);
        run_op("remu 3%ffff",  REMU, 32'd3, 32'hFFFF_FFFF, 32'd3, 33, 1'b0);

        // Unsupported code must not disturb the unit or the held result.
        @(posedge clk); #1;
        start = 1'b1; alu_control = 3'b000; dividend = 32'd50; divisor = 32'd5;
        #1;
        check("ignored stall", {31'b0, stall}, 0);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            busy_cnt += int'(busy) + int'(done);
        end
        check("ignored busy_done", busy_cnt, 0);
        check("ignored result", result, 32'd3);
        start = 1'b0;

        run_op("div 5/0",      DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu 5/0",     REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);

        run_op("div hold 21/4", DIV, 32'd21, 32'd4, 32'd5, 33, 1'b1);
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            done_cnt += int'(done);
            busy_cnt += int'(busy);
        end
        check("hold extra_done", done_cnt, 0);
        check("hold busy_after", busy_cnt, 0);

        // Second op issued in the cycle right after the first done pulse.
        run_op("b2b first 77/7",  DIV, 32'd77, 32'd7, 32'd11, 33, 1'b0);
        run_op("b2b second 9%4",  REMU, 32'd9, 32'd4, 32'd1, 33, 1'b0);

        // Reset at cycle 10 of DIV 1000/3.
        @(posedge clk); #1;
        start = 1'b1; alu_control = DIV; dividend = 32'd1000; divisor = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #2;
        check("rst_mid busy",   {31'b0, busy}, 0);
        check("rst_mid result", result, 0);
        check("rst_mid done",   {31'b0, done}, 0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            done_cnt += int'(done);
        end
        check("rst_mid late_done", done_cnt, 0);

        run_op("div 9/3 after rst", DIV, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
